// File: rtl/ntsc_line_fetch.sv
// ---------------------------------------------------------------------------
// ntsc_line_fetch
//
// Scanline prefetch controller that sits between the NTSC encoder and the
// video-memory arbiter. Each visible row is copied from framebuffer RAM into
// one of two ping-pong line buffers (row r lives in buffer r[0]) one row ahead
// of the encoder. Pixels are served back to the encoder by column with one
// cycle of registered latency.
//
// Ports
//   clock        in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   ctrlRegVal   in   64  [0]=enable, [1]=double-scan, [31:8]=fb base word addr
//   pixPosX      in   10  encoder pixel column
//   pixPosY      in   10  encoder row (0 during blanking)
//   pixLineOdd   in   1   field parity, any toggle marks a field start
//   pixCy        out  8   Y of the requested pixel
//   pixCu        out  8   U of the requested pixel
//   pixCv        out  8   V of the requested pixel
//   memReq       out  1   fetch request, held until memAck
//   memAddr      out  24  word address, stable while memReq=1
//   memAck       in   1   one-cycle pulse: memData valid, request consumed
//   memData      in   64  [31:0]=even pixel, [63:32]=odd pixel, {8'h00,Y,U,V}
//   fetchStat    out  4   [0]=busy [1]=underrun [2]=overrun [3]=row pending
//
// Build option
//   NTSC_FETCH_DBLSCAN_EN : when defined, ctrlRegVal[1]=1 makes every source
//   row be shown twice (the row base only advances after odd rows).
// ---------------------------------------------------------------------------
module ntsc_line_fetch #(
  parameter int          LINE_WORDS  = 320,
  parameter int          VIS_ROWS    = 240,
  parameter logic [23:0] LINE_STRIDE = 24'h140
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] ctrlRegVal,
  input  logic [9:0]  pixPosX,
  input  logic [9:0]  pixPosY,
  input  logic        pixLineOdd,
  output logic [7:0]  pixCy,
  output logic [7:0]  pixCu,
  output logic [7:0]  pixCv,
  output logic        memReq,
  output logic [23:0] memAddr,
  input  logic        memAck,
  input  logic [63:0] memData,
  output logic [3:0]  fetchStat
);

  localparam int                WORD_W    = $clog2(LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  // Sequential state
  state_t            r_state;
  logic              r_memReq;
  logic [23:0]       r_memAddr;
  logic [WORD_W-1:0] r_word;
  logic [9:0]        r_row;
  logic [23:0]       r_rowBase;
  logic              r_pendValid;
  logic [9:0]        r_pendRow;
  logic              r_discard;
  logic [1:0]        r_ready;
  logic              r_overrun;
  logic              r_underrun;
  logic              r_lineOddPrev;
  logic [9:0]        r_posYPrev;
  logic [7:0]        r_pixCy;
  logic [7:0]        r_pixCu;
  logic [7:0]        r_pixCv;
  logic [63:0]       r_buf0 [LINE_WORDS];
  logic [63:0]       r_buf1 [LINE_WORDS];

  // Combinational next values and controls
  state_t            w_stateNext;
  logic              w_memReqNext;
  logic [23:0]       w_memAddrNext;
  logic [WORD_W-1:0] w_wordNext;
  logic [9:0]        w_rowNext;
  logic [23:0]       w_rowBaseNext;
  logic              w_pendValidNext;
  logic [9:0]        w_pendRowNext;
  logic              w_discardNext;
  logic [1:0]        w_readySet;
  logic [1:0]        w_readyClr;
  logic              w_overrunSet;
  logic              w_bufWe;
  logic              w_done;
  logic              w_launch;
  logic [9:0]        w_launchRow;

  logic              w_enable;
  logic [23:0]       w_fbBase;
  logic              w_fieldStart;
  logic              w_rowTrig;
  logic [9:0]        w_trigRow;
  logic [23:0]       w_advBase;
  logic [WORD_W-1:0] w_rdIdx;
  logic              w_inLine;
  logic [63:0]       w_rdWord;
  logic [23:0]       w_rdPix;
  logic              w_unusedBits;

  assign w_enable = ctrlRegVal[0];
  assign w_fbBase = ctrlRegVal[31:8];

  // A field start restarts the whole field; it outranks a row trigger.
  assign w_fieldStart = w_enable && (pixLineOdd != r_lineOddPrev);
  assign w_trigRow    = pixPosY + 10'd1;
  assign w_rowTrig    = w_enable && !w_fieldStart &&
                        (pixPosY != r_posYPrev) && (pixPosY != 10'd0) &&
                        (({1'b0, pixPosY} + 11'd1) < 11'(VIS_ROWS));

  // Base for the row after the current one. In double-scan mode even rows
  // reuse their source row so each source row appears on two output rows.
`ifdef NTSC_FETCH_DBLSCAN_EN
  assign w_advBase = (ctrlRegVal[1] && !r_row[0]) ? r_rowBase
                                                  : r_rowBase + LINE_STRIDE;
  assign w_unusedBits = ^{ctrlRegVal[63:32], ctrlRegVal[7:2],
                          w_rdWord[63:56], w_rdWord[31:24]};
`else
  assign w_advBase = r_rowBase + LINE_STRIDE;
  assign w_unusedBits = ^{ctrlRegVal[63:32], ctrlRegVal[7:1],
                          w_rdWord[63:56], w_rdWord[31:24]};
`endif

  // Next-state and datapath control. The queue is one active row (r_row)
  // plus one pending row. A field start that lands while a request is
  // outstanding cannot retract it, so the request is left on the bus and its
  // data is thrown away (r_discard) before the new field's first word.
  always_comb begin
    w_stateNext     = r_state;
    w_memReqNext    = r_memReq;
    w_memAddrNext   = r_memAddr;
    w_wordNext      = r_word;
    w_rowNext       = r_row;
    w_rowBaseNext   = r_rowBase;
    w_pendValidNext = r_pendValid;
    w_pendRowNext   = r_pendRow;
    w_discardNext   = r_discard;
    w_readySet      = 2'b00;
    w_readyClr      = 2'b00;
    w_overrunSet    = 1'b0;
    w_bufWe         = 1'b0;
    w_done          = 1'b0;
    w_launch        = 1'b0;
    w_launchRow     = '0;

    if (!w_enable) begin
      // Let the outstanding word finish, then park; the row stays not-ready.
      w_pendValidNext = 1'b0;
      if (r_state == ST_FETCH) begin
        if (!r_memReq) begin
          w_stateNext = ST_IDLE;
        end else if (memAck) begin
          w_bufWe       = !r_discard;
          w_memReqNext  = 1'b0;
          w_discardNext = 1'b0;
          w_stateNext   = ST_IDLE;
        end
      end
    end else if (w_fieldStart) begin
      w_rowNext       = '0;
      w_wordNext      = '0;
      w_rowBaseNext   = w_fbBase;
      w_pendValidNext = 1'b1;
      w_pendRowNext   = 10'd1;
      w_readyClr      = 2'b11;
      w_stateNext     = ST_FETCH;
      if (r_state == ST_FETCH && r_memReq && !memAck) begin
        w_discardNext = 1'b1;
      end else begin
        w_memReqNext  = 1'b1;
        w_memAddrNext = w_fbBase;
        w_discardNext = 1'b0;
      end
    end else begin
      if (r_state == ST_FETCH) begin
        if (!r_memReq) begin
          w_memReqNext = 1'b1;
        end else if (memAck) begin
          if (r_discard) begin
            w_discardNext = 1'b0;
            w_memAddrNext = r_rowBase + 24'(r_word);
          end else begin
            w_bufWe = 1'b1;
            if (r_word == LAST_WORD) begin
              w_done                = 1'b1;
              w_memReqNext          = 1'b0;
              w_readySet[r_row[0]]  = 1'b1;
              w_rowBaseNext         = w_advBase;
            end else begin
              w_wordNext    = r_word + WORD_W'(1);
              w_memAddrNext = r_rowBase + 24'(r_word) + 24'd1;
            end
          end
        end
      end

      // Queue management: a free slot launches the pending row first.
      if (r_state == ST_IDLE || w_done) begin
        if (r_pendValid) begin
          w_launch        = 1'b1;
          w_launchRow     = r_pendRow;
          w_pendValidNext = w_rowTrig;
          w_pendRowNext   = w_trigRow;
        end else if (w_rowTrig) begin
          w_launch    = 1'b1;
          w_launchRow = w_trigRow;
        end else if (w_done) begin
          w_stateNext = ST_IDLE;
        end
      end else if (w_rowTrig) begin
        if (r_pendValid) begin
          w_overrunSet = 1'b1;
        end else begin
          w_pendValidNext = 1'b1;
          w_pendRowNext   = w_trigRow;
        end
      end

      // Launching right after a completed row drops memReq for one cycle
      // and raises it again from FETCH; launching from IDLE raises it now.
      if (w_launch) begin
        w_stateNext                = ST_FETCH;
        w_rowNext                  = w_launchRow;
        w_wordNext                 = '0;
        w_readyClr[w_launchRow[0]] = 1'b1;
        w_memAddrNext              = w_rowBaseNext;
        w_memReqNext               = !w_done;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Fetch datapath, queue and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_memReq      <= 1'b0;
      r_memAddr     <= '0;
      r_word        <= '0;
      r_row         <= '0;
      r_rowBase     <= '0;
      r_pendValid   <= 1'b0;
      r_pendRow     <= '0;
      r_discard     <= 1'b0;
      r_ready       <= 2'b00;
      r_overrun     <= 1'b0;
      r_lineOddPrev <= 1'b0;
      r_posYPrev    <= '0;
    end else begin
      r_memReq      <= w_memReqNext;
      r_memAddr     <= w_memAddrNext;
      r_word        <= w_wordNext;
      r_row         <= w_rowNext;
      r_rowBase     <= w_rowBaseNext;
      r_pendValid   <= w_pendValidNext;
      r_pendRow     <= w_pendRowNext;
      r_discard     <= w_discardNext;
      r_ready       <= (r_ready | w_readySet) & ~w_readyClr;
      r_overrun     <= w_enable ? (r_overrun | w_overrunSet) : 1'b0;
      r_lineOddPrev <= pixLineOdd;
      r_posYPrev    <= pixPosY;
    end
  end

  // Line buffer storage, written with the word just acknowledged.
  always_ff @(posedge clock) begin
    if (w_bufWe) begin
      if (r_row[0]) begin
        r_buf1[r_word] <= memData;
      end else begin
        r_buf0[r_word] <= memData;
      end
    end
  end

  // Read address: columns past the visible line clamp to the last word.
  always_comb begin
    if ({1'b0, pixPosX} >= 11'(2 * LINE_WORDS)) begin
      w_rdIdx  = LAST_WORD;
      w_inLine = 1'b0;
    end else begin
      w_rdIdx  = WORD_W'(pixPosX[9:1]);
      w_inLine = 1'b1;
    end
    w_rdWord = pixPosY[0] ? r_buf1[w_rdIdx] : r_buf0[w_rdIdx];
    w_rdPix  = pixPosX[0] ? w_rdWord[55:32] : w_rdWord[23:0];
  end

  // Pixel output register. A read of a buffer being written this cycle sees
  // the old word. Missing rows show black and flag an underrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pixCy    <= 8'h00;
      r_pixCu    <= 8'h80;
      r_pixCv    <= 8'h80;
      r_underrun <= 1'b0;
    end else if (!w_enable) begin
      r_pixCy    <= 8'h00;
      r_pixCu    <= 8'h80;
      r_pixCv    <= 8'h80;
      r_underrun <= 1'b0;
    end else if (r_ready[pixPosY[0]]) begin
      {r_pixCy, r_pixCu, r_pixCv} <= w_rdPix;
    end else begin
      r_pixCy <= 8'h00;
      r_pixCu <= 8'h80;
      r_pixCv <= 8'h80;
      if (w_inLine && (pixPosX != 10'd0)) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign pixCy     = r_pixCy;
  assign pixCu     = r_pixCu;
  assign pixCv     = r_pixCv;
  assign memReq    = r_memReq;
  assign memAddr   = r_memAddr;
  assign fetchStat = {r_pendValid, r_overrun, r_underrun, (r_state == ST_FETCH)};

endmodule

// File: tb/tb_ntsc_line_fetch.sv
// ---------------------------------------------------------------------------
// tb_ntsc_line_fetch
//
// Directed bench for ntsc_line_fetch. A memory responder acknowledges each
// request two cycles after it is seen, returning a data pattern derived from
// the word address. Pixel readout is checked from a vector table; multi-cycle
// behaviour (queueing, overrun, underrun, disable, reset) by sequences.
// ---------------------------------------------------------------------------
module tb_ntsc_line_fetch;

  localparam int ACK_DELAY = 2;

  logic        clock;
  logic        reset;
  logic [63:0] ctrlRegVal;
  logic [9:0]  pixPosX;
  logic [9:0]  pixPosY;
  logic        pixLineOdd;
  logic [7:0]  pixCy;
  logic [7:0]  pixCu;
  logic [7:0]  pixCv;
  logic        memReq;
  logic [23:0] memAddr;
  logic        memAck;
  logic [63:0] memData;
  logic [3:0]  fetchStat;

  int          testsRun  = 0;
  int          failCount = 0;
  bit          ackHold   = 1'b0;
  logic [23:0] ackLog[$];

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] pix;
  } vec_t;

  vec_t vecs[11];

  ntsc_line_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .ctrlRegVal (ctrlRegVal),
    .pixPosX    (pixPosX),
    .pixPosY    (pixPosY),
    .pixLineOdd (pixLineOdd),
    .pixCy      (pixCy),
    .pixCu      (pixCu),
    .pixCv      (pixCv),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData),
    .fetchStat  (fetchStat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: one fixed word for the row-0 word-5 vector, otherwise
  // even pixel {addr[7:0], addr[15:8], 40}, odd pixel {~addr[7:0], 55, addr[7:0]+1}.
  function automatic logic [63:0] memModel(input logic [23:0] a);
    if (a == 24'h001005) begin
      return 64'h00A0B0C0_00102030;
    end
    return {8'h00, ~a[7:0], 8'h55, a[7:0] + 8'h01,
            8'h00, a[7:0], a[15:8], 8'h40};
  endfunction

  // Memory responder: acknowledges a held request after ACK_DELAY cycles.
  initial begin : responder
    int waitCnt;
    waitCnt = 0;
    memAck  = 1'b0;
    memData = '0;
    forever begin
      @(posedge clock);
      #1;
      memAck = 1'b0;
      if (memReq && !ackHold && !reset) begin
        if (waitCnt >= ACK_DELAY - 1) begin
          memAck  = 1'b1;
          memData = memModel(memAddr);
          ackLog.push_back(memAddr);
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
    @(negedge clock);
    pixPosX = x;
    pixPosY = y;
  endtask

  task automatic waitAcks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (ackLog.size() < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    checkOutput(name, 32'(ackLog.size() >= target), 32'd1);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    #1;
    while (fetchStat[0] && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput(name, 32'(fetchStat[0]), 32'd0);
  endtask

  initial begin : main
    int seqErr;
    int base;

    vecs[0]  = '{x: 10'd10,   y: 10'd0, pix: 24'h102030};
    vecs[1]  = '{x: 10'd11,   y: 10'd0, pix: 24'hA0B0C0};
    vecs[2]  = '{x: 10'd0,    y: 10'd0, pix: 24'h001040};
    vecs[3]  = '{x: 10'd1,    y: 10'd0, pix: 24'hFF5501};
    vecs[4]  = '{x: 10'd639,  y: 10'd0, pix: 24'hC05540};
    vecs[5]  = '{x: 10'd700,  y: 10'd0, pix: 24'h3F1140};
    vecs[6]  = '{x: 10'd1023, y: 10'd0, pix: 24'hC05540};
    vecs[7]  = '{x: 10'd0,    y: 10'd1, pix: 24'h401140};
    vecs[8]  = '{x: 10'd3,    y: 10'd1, pix: 24'hBE5542};
    vecs[9]  = '{x: 10'd200,  y: 10'd1, pix: 24'hA41140};
    vecs[10] = '{x: 10'd641,  y: 10'd1, pix: 24'h805580};

    reset      = 1'b1;
    ctrlRegVal = '0;
    pixPosX    = '0;
    pixPosY    = '0;
    pixLineOdd = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstMemReq",  32'(memReq),    32'd0);
    checkOutput("rstMemAddr", 32'(memAddr),   32'd0);
    checkOutput("rstPixCy",   32'(pixCy),     32'h00);
    checkOutput("rstPixCu",   32'(pixCu),     32'h80);
    checkOutput("rstPixCv",   32'(pixCv),     32'h80);
    checkOutput("rstStat",    32'(fetchStat), 32'd0);

    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ctrlRegVal = {32'h0, 24'h001000, 8'h01};

    // Field start fetches rows 0 and 1
    @(negedge clock);
    pixLineOdd = 1'b1;
    waitAcks(640, 4000, "field0Acks");
    waitIdle(200, "field0Idle");
    checkOutput("row0First", 32'(ackLog[0]),   32'h001000);
    checkOutput("row0Last",  32'(ackLog[319]), 32'h00113F);
    checkOutput("row1First", 32'(ackLog[320]), 32'h001140);
    checkOutput("row1Last",  32'(ackLog[639]), 32'h00127F);
    seqErr = 0;
    for (int i = 0; i < 640; i++) begin
      if (ackLog[i] != 24'h001000 + 24'(i)) seqErr++;
    end
    checkOutput("field0AddrSeq", 32'(seqErr),    32'd0);
    checkOutput("field0Stat",    32'(fetchStat), 32'd0);

    // Readout table; the step to pixPosY=1 also starts row 2
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y);
      @(posedge clock);
      #1;
      checkOutput($sformatf("read%0d", i), {8'h00, pixCy, pixCu, pixCv}, {8'h00, vecs[i].pix});
    end
    checkOutput("noUnderrun", 32'(fetchStat[1]), 32'd0);
    checkOutput("row2Busy",   32'(fetchStat[0]), 32'd1);

    // Second trigger during row 2 queues row 3; a third one overruns
    applyStimulus(10'd0, 10'd2);
    @(posedge clock);
    #1;
    checkOutput("row3Pending", 32'(fetchStat[3]), 32'd1);
    checkOutput("noOverrun",   32'(fetchStat[2]), 32'd0);
    applyStimulus(10'd0, 10'd3);
    @(posedge clock);
    #1;
    checkOutput("overrunSet", 32'(fetchStat[2]), 32'd1);
    waitAcks(1280, 5000, "rows23Acks");
    waitIdle(200, "rows23Idle");
    checkOutput("row2First",   32'(ackLog[640]), 32'h001280);
    checkOutput("row2Last",    32'(ackLog[959]), 32'h0013BF);
    checkOutput("row3First",   32'(ackLog[960]), 32'h0013C0);
    checkOutput("overrunKeep", 32'(fetchStat[2]), 32'd1);
    checkOutput("pendingDone", 32'(fetchStat[3]), 32'd0);

    // Row 2 content (from 1280); moving to pixPosY=2 refetches row 3
    applyStimulus(10'd4, 10'd2);
    @(posedge clock);
    #1;
    checkOutput("row2Read", {8'h00, pixCy, pixCu, pixCv}, 32'h00821240);
    waitAcks(1600, 5000, "row3bAcks");
    waitIdle(200, "row3bIdle");

    // Underrun: stall row 1 of a new field, then read it
    applyStimulus(10'd0, 10'd0);
    @(negedge clock);
    pixLineOdd = 1'b0;
    base = ackLog.size();
    waitAcks(base + 330, 4000, "stallAcks");
    ackHold = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("stallBusy", 32'(fetchStat[0]), 32'd1);
    applyStimulus(10'd5, 10'd1);
    @(posedge clock);
    #1;
    checkOutput("underrunBlack", {8'h00, pixCy, pixCu, pixCv}, 32'h00008080);
    checkOutput("underrunSet",   32'(fetchStat[1]), 32'd1);
    applyStimulus(10'd0, 10'd1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("underrunSticky", 32'(fetchStat[1]), 32'd1);

    // Disable: stickies and pending clear, in-flight word still completes
    @(negedge clock);
    ctrlRegVal[0] = 1'b0;
    pixPosX = 10'd3;
    @(posedge clock);
    #1;
    checkOutput("disUnderrun", 32'(fetchStat[1]), 32'd0);
    checkOutput("disOverrun",  32'(fetchStat[2]), 32'd0);
    checkOutput("disPending",  32'(fetchStat[3]), 32'd0);
    checkOutput("disBlack",    {8'h00, pixCy, pixCu, pixCv}, 32'h00008080);
    checkOutput("disReqHeld",  32'(memReq), 32'd1);
    @(negedge clock);
    ackHold = 1'b0;
    waitIdle(20, "disIdle");
    checkOutput("disReqDrop", 32'(memReq), 32'd0);

    // Re-enable without triggers: row 1 was left not-ready
    @(negedge clock);
    ctrlRegVal[0] = 1'b1;
    applyStimulus(10'd7, 10'd1);
    @(posedge clock);
    #1;
    checkOutput("reenBlack",    {8'h00, pixCy, pixCu, pixCv}, 32'h00008080);
    checkOutput("reenUnderrun", 32'(fetchStat[1]), 32'd1);
    checkOutput("reenIdle",     32'(fetchStat[0]), 32'd0);

    // Reset in the middle of a fetch at word 100
    applyStimulus(10'd0, 10'd0);
    @(negedge clock);
    pixLineOdd = 1'b1;
    base = ackLog.size();
    waitAcks(base + 100, 2000, "midAcks");
    ackHold = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("midReq",  32'(memReq),  32'd1);
    checkOutput("midAddr", 32'(memAddr), 32'h001064);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstReq",  32'(memReq),    32'd0);
    checkOutput("midRstAddr", 32'(memAddr),   32'd0);
    checkOutput("midRstPix",  {8'h00, pixCy, pixCu, pixCv}, 32'h00008080);
    checkOutput("midRstStat", 32'(fetchStat), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
